// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants for the byte-enable data-memory responder
// State encoding, CPU-matching byte-enable patterns and the DM byte limit.
package dm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] BE_READ = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [31:0] DM_BYTE_LIMIT = 32'h0000_3000;

endpackage

// File: rtl/dm_be_responder_if.sv
// rtl/dm_be_responder_if.sv - request/response bus between M-stage and data memory
// master is the CPU-side requester, slave is the responder.
interface dm_be_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_byte_merge.sv
// rtl/dm_byte_merge.sv - lane merge of store data into the old word, plus be/alignment legality
// Purely combinational; the caller decides whether the merged word is written.
module dm_byte_merge
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged,
  output logic        legal
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Halves are checked on addr[1] only, matching the CPU-side generator.
  always_comb begin
    case (be)
      BE_READ: legal = 1'b1;
      BE_B0:   legal = (addr_lo == 2'b00);
      BE_B1:   legal = (addr_lo == 2'b01);
      BE_B2:   legal = (addr_lo == 2'b10);
      BE_B3:   legal = (addr_lo == 2'b11);
      BE_HLO:  legal = !addr_lo[1];
      BE_HHI:  legal = addr_lo[1];
      BE_WORD: legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_be_responder.sv
// rtl/dm_be_responder.sv - single-outstanding byte-enable data-memory responder
// Accepts a request in IDLE, waits WAIT_CYCLES, commits, then holds the response until consumed.
module dm_be_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  dm_be_responder_if.slave   bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit, in_range, legal, is_write, mem_we;
  logic [31:0]   cur_addr, cur_wdata, old_word, merged;
  logic [3:0]    cur_be;
  logic [AW-1:0] word_idx;

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  // With zero wait states the commit uses the live request, otherwise the captured one.
  assign cur_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign cur_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;
  assign cur_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;

  assign commit   = (accept && (WAIT_LOAD == 4'd0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
  assign in_range = (cur_addr < ADDR_LIMIT);
  assign word_idx = cur_addr[AW+1:2];
  assign old_word = in_range ? mem[word_idx] : 32'h0;
  assign is_write = (cur_be != BE_READ);
  assign mem_we   = commit && in_range && legal && is_write && reset_n;

  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .be       (cur_be),
    .addr_lo  (cur_addr[1:0]),
    .merged   (merged),
    .legal    (legal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          be_d    = bus.req_be;
          wdata_d = bus.req_wdata;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      err_d   = !(in_range && legal);
      rdata_d = (in_range && legal && !is_write) ? old_word : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      be_q    <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= merged;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
